bit_serializer: RTL

//   Upstream stage for the serial '101' Moore sequence detector.

---
 rtl/fsm_pkg.sv | 12 +
 rtl/piso_shreg.sv | 38 +++
 rtl/bit_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// Shared FSM definitions for the serializer and the downstream '101' detector.
package fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in/serial-out register; q_bit is the bit to be placed on the line at this edge.
module piso_shreg
    import fsm_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_bit
);

    localparam int unsigned FIRST = MSB_FIRST ? WIDTH - 1 : 0;

    logic [WIDTH-1:0] r_shreg;

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? {x[WIDTH-2:0], 1'b0} : {1'b0, x[WIDTH-1:1]};
    endfunction

    // The register holds only bits not yet emitted, so a load stores d already advanced
    // by one: the first bit goes straight to the caller's output register at the load edge.
    always_ff @(posedge clk) begin
        if (reset == RST_ACTIVE) begin
            r_shreg <= '0;
        end else if (load) begin
            r_shreg <= advance(d);
        end else if (shift) begin
            r_shreg <= advance(r_shreg);
        end
    end

    assign q_bit = load ? d[FIRST] : r_shreg[FIRST];

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit serializer feeding the serial '101' detector; valid/ready input, optional idle gap.
module bit_serializer
    import fsm_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 0,
    parameter bit          IDLE_LEVEL = 1'b0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int unsigned    BCW      = $clog2(WIDTH);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [7:0]     GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [BCW-1:0]   r_bit_cnt;
    logic [7:0]       r_gap_cnt;
    logic [CNT_W-1:0] r_words_sent;
    logic             r_out_bit;
    logic             r_out_valid;

    logic w_in_ready;
    logic w_accept;
    logic w_last_bit;
    logic w_gap_done;
    logic w_shift;
    logic w_q_bit;

    piso_shreg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shreg (
        .clk  (clk),
        .reset(reset),
        .load (w_accept),
        .shift(w_shift),
        .d    (in_data),
        .q_bit(w_q_bit)
    );

    always_comb begin
        w_last_bit   = (r_state == ST_SHIFT) && (r_bit_cnt == BIT_LAST);
        w_gap_done   = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);
        w_in_ready   = (reset != RST_ACTIVE) &&
                       ((r_state == ST_IDLE) || (w_last_bit && (GAP_CYCLES == 0)));
        w_accept     = in_valid && w_in_ready;
        w_shift      = (r_state == ST_SHIFT) && !w_last_bit;
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_last_bit) begin
                    if (GAP_CYCLES != 0) w_next_state = ST_GAP;
                    else if (w_accept)   w_next_state = ST_SHIFT;
                    else                 w_next_state = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (w_gap_done) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset == RST_ACTIVE) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Output registers track the state being entered, so bits line up with SHIFT cycles.
    always_ff @(posedge clk) begin
        if (reset == RST_ACTIVE) begin
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_words_sent <= '0;
            r_out_bit    <= IDLE_LEVEL;
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid <= (w_next_state == ST_SHIFT);
            r_out_bit   <= (w_next_state == ST_SHIFT) ? w_q_bit : IDLE_LEVEL;
            if (w_accept || w_last_bit) begin
                r_bit_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
            if ((r_state == ST_GAP) && !w_gap_done) begin
                r_gap_cnt <= r_gap_cnt + 8'd1;
            end else begin
                r_gap_cnt <= '0;
            end
            if (w_last_bit) begin
                r_words_sent <= r_words_sent + CNT_W'(1);
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_bit    = r_out_bit;
    assign out_valid  = r_out_valid;
    assign busy       = (r_state != ST_IDLE);
    assign words_sent = r_words_sent;

endmodule
